// File: rtl/qsys_serial_endpoint.sv
// Far-end endpoint of the Qsys serial link. It collects a 65-bit command frame, runs one
// local register-bus access, and shifts a 32-bit response back to the bridge.
module qsys_serial_endpoint #(
  parameter int          ADDR_W     = 8,
  parameter int          LB_TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic              ser_le,
  input  logic              ser_din,
  output logic              ser_dout,
  output logic              ser_rdy,
  output logic [ADDR_W-1:0] lb_address,
  output logic [31:0]       lb_writedata,
  output logic              lb_write,
  output logic              lb_read,
  input  logic [31:0]       lb_readdata,
  input  logic              lb_waitrequest,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, EXEC, RESP, GAP} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(LB_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [64:0]         shreg_q, shreg_d;
  logic [6:0]          bitcnt_q, bitcnt_d;
  logic [15:0]         waitcnt_q, waitcnt_d;
  logic [31:0]         resp_q, resp_d;
  logic [5:0]          respidx_q, respidx_d;
  logic                le_q;
  logic                drop_q, drop_d;
  logic [7:0]          err_count_d;
  logic                ser_dout_d, ser_rdy_d;
  logic [ADDR_W-1:0]   lb_address_d;
  logic [31:0]         lb_writedata_d;
  logic                lb_write_d, lb_read_d;
  logic [1:0]          err_inc;
  logic [8:0]          err_sum;
  logic                busy_rise;

  if (ADDR_W < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^shreg_q[63:32+ADDR_W];
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      waitcnt_q    <= '0;
      resp_q       <= '0;
      respidx_q    <= '0;
      le_q         <= 1'b0;
      drop_q       <= 1'b0;
      err_count    <= '0;
      ser_dout     <= 1'b0;
      ser_rdy      <= 1'b0;
      lb_address   <= '0;
      lb_writedata <= '0;
      lb_write     <= 1'b0;
      lb_read      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      waitcnt_q    <= waitcnt_d;
      resp_q       <= resp_d;
      respidx_q    <= respidx_d;
      le_q         <= ser_le;
      drop_q       <= drop_d;
      err_count    <= err_count_d;
      ser_dout     <= ser_dout_d;
      ser_rdy      <= ser_rdy_d;
      lb_address   <= lb_address_d;
      lb_writedata <= lb_writedata_d;
      lb_write     <= lb_write_d;
      lb_read      <= lb_read_d;
    end
  end

  // A burst that starts while busy is counted once and then shut out until ser_le drops,
  // so its tail cannot be mistaken for a new frame once we are back in IDLE.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bitcnt_d       = bitcnt_q;
    waitcnt_d      = waitcnt_q;
    resp_d         = resp_q;
    respidx_d      = respidx_q;
    ser_dout_d     = ser_dout;
    ser_rdy_d      = ser_rdy;
    lb_address_d   = lb_address;
    lb_writedata_d = lb_writedata;
    lb_write_d     = lb_write;
    lb_read_d      = lb_read;
    err_inc        = 2'd0;
    drop_d         = drop_q & ser_le;
    busy_rise      = ser_le & ~le_q &
                     ((state_q == EXEC) | (state_q == RESP) | (state_q == GAP));

    if (busy_rise) begin
      err_inc = err_inc + 2'd1;
      drop_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ser_le && !drop_q) begin
          shreg_d  = {64'b0, ser_din};
          bitcnt_d = 7'd1;
          state_d  = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        if (ser_le) begin
          shreg_d = {shreg_q[63:0], ser_din};
          if (bitcnt_q != 7'd127) bitcnt_d = bitcnt_q + 7'd1;
        end else if (bitcnt_q == 7'd65) begin
          lb_address_d   = shreg_q[ADDR_W+31:32];
          lb_writedata_d = shreg_q[31:0];
          lb_write_d     = shreg_q[64];
          lb_read_d      = ~shreg_q[64];
          waitcnt_d      = '0;
          state_d        = EXEC;
        end else begin
          err_inc = err_inc + 2'd1;
          state_d = IDLE;
        end
      end
      EXEC: begin
        // Completion takes priority over a timeout landing on the same edge.
        if (!lb_waitrequest) begin
          resp_d     = lb_read ? lb_readdata : 32'h0;
          lb_write_d = 1'b0;
          lb_read_d  = 1'b0;
          respidx_d  = '0;
          state_d    = RESP;
        end else if (waitcnt_q == WAIT_LAST) begin
          resp_d     = ERR_DATA;
          lb_write_d = 1'b0;
          lb_read_d  = 1'b0;
          respidx_d  = '0;
          err_inc    = err_inc + 2'd1;
          state_d    = RESP;
        end else begin
          waitcnt_d = waitcnt_q + 16'd1;
        end
      end
      RESP: begin
        respidx_d = respidx_q + 6'd1;
        if (respidx_q == 6'd33) begin
          ser_rdy_d  = 1'b0;
          ser_dout_d = 1'b0;
          state_d    = GAP;
        end else if (respidx_q == 6'd0) begin
          ser_rdy_d  = 1'b1;
          ser_dout_d = 1'b0;
        end else begin
          ser_rdy_d  = 1'b1;
          ser_dout_d = resp_q[31];
          resp_d     = {resp_q[30:0], 1'b0};
        end
      end
      GAP: begin
        ser_rdy_d  = 1'b0;
        ser_dout_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_sum     = {1'b0, err_count} + {7'b0, err_inc};
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

endmodule

// File: tb/tb_qsys_serial_endpoint.sv
// Directed bench for qsys_serial_endpoint: table of frame/bus vectors plus hand-written
// sequences for malformed frames, busy-time bursts and reset during an access.
module tb_qsys_serial_endpoint;

  localparam int          ADDR_W = 8;
  localparam int          TMO    = 16;
  localparam logic [31:0] ERRD   = 32'hDEAD_BEEF;

  logic              csi_MCLK_clk;
  logic              rsi_MRST_reset;
  logic              ser_le;
  logic              ser_din;
  logic              ser_dout;
  logic              ser_rdy;
  logic [ADDR_W-1:0] lb_address;
  logic [31:0]       lb_writedata;
  logic              lb_write;
  logic              lb_read;
  logic [31:0]       lb_readdata;
  logic              lb_waitrequest;
  logic [7:0]        err_count;

  qsys_serial_endpoint #(.ADDR_W(ADDR_W), .LB_TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .csi_MCLK_clk   (csi_MCLK_clk),
    .rsi_MRST_reset (rsi_MRST_reset),
    .ser_le         (ser_le),
    .ser_din        (ser_din),
    .ser_dout       (ser_dout),
    .ser_rdy        (ser_rdy),
    .lb_address     (lb_address),
    .lb_writedata   (lb_writedata),
    .lb_write       (lb_write),
    .lb_read        (lb_read),
    .lb_readdata    (lb_readdata),
    .lb_waitrequest (lb_waitrequest),
    .err_count      (err_count)
  );

  initial csi_MCLK_clk = 1'b0;
  always #5 csi_MCLK_clk = ~csi_MCLK_clk;

  typedef struct {
    logic              w;
    logic [31:0]       addr;
    logic [31:0]       data;
    logic [31:0]       rdata;
    int                waits;
    int                burst_start;
    int                burst_len;
    logic [ADDR_W-1:0] exp_addr;
    int                exp_strobe;
    logic [31:0]       exp_resp;
    int                exp_err_inc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  int                obs_wr, obs_rd, obs_first, obs_unstable;
  int                obs_rdy_first, obs_rdy_cycles;
  logic [ADDR_W-1:0] obs_addr;
  logic [31:0]       obs_wdata;
  logic [32:0]       obs_bits;
  logic              obs_done;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendFrame(input logic [127:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge csi_MCLK_clk);
      ser_le  = 1'b1;
      ser_din = bits[i];
    end
    @(negedge csi_MCLK_clk);
    ser_le  = 1'b0;
    ser_din = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [127:0] fr;
    fr = '0;
    fr[64:0] = {v.w, v.addr, v.data};
    obs_wr = 0; obs_rd = 0; obs_first = 0; obs_unstable = 0;
    obs_rdy_first = 0; obs_rdy_cycles = 0; obs_bits = '0; obs_done = 1'b0;
    obs_addr = '0; obs_wdata = '0;
    lb_readdata    = v.rdata;
    lb_waitrequest = (v.waits > 0);
    sendFrame(fr, 65);
    for (int c = 1; c <= 400 && !obs_done; c++) begin
      @(negedge csi_MCLK_clk);
      if (lb_write || lb_read) begin
        if (obs_first == 0) begin
          obs_first = c;
          obs_addr  = lb_address;
          obs_wdata = lb_writedata;
        end
        if (lb_address !== obs_addr || lb_writedata !== obs_wdata) obs_unstable++;
        if (lb_write) obs_wr++;
        if (lb_read)  obs_rd++;
      end
      if (ser_rdy) begin
        if (obs_rdy_first == 0) obs_rdy_first = c;
        obs_rdy_cycles++;
        obs_bits = {obs_bits[31:0], ser_dout};
      end else if (obs_rdy_cycles > 0) begin
        obs_done = 1'b1;
      end
      lb_waitrequest = (c <= v.waits);
      ser_le  = (v.burst_len > 0) && (c >= v.burst_start) && (c < v.burst_start + v.burst_len);
      ser_din = c[0];
    end
    ser_le         = 1'b0;
    ser_din        = 1'b0;
    lb_waitrequest = 1'b0;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d_done", i), 64'(obs_done), 64'd1);
    checkOutput($sformatf("v%0d_strobe_start", i), 64'(obs_first), 64'd1);
    checkOutput($sformatf("v%0d_write_cycles", i), 64'(obs_wr), 64'(v.w ? v.exp_strobe : 0));
    checkOutput($sformatf("v%0d_read_cycles", i), 64'(obs_rd), 64'(v.w ? 0 : v.exp_strobe));
    checkOutput($sformatf("v%0d_address", i), 64'(obs_addr), 64'(v.exp_addr));
    if (v.w) checkOutput($sformatf("v%0d_writedata", i), 64'(obs_wdata), 64'(v.data));
    checkOutput($sformatf("v%0d_bus_stable", i), 64'(obs_unstable), 64'd0);
    checkOutput($sformatf("v%0d_rdy_rise", i), 64'(obs_rdy_first), 64'(v.exp_strobe + 2));
    checkOutput($sformatf("v%0d_rdy_cycles", i), 64'(obs_rdy_cycles), 64'd33);
    checkOutput($sformatf("v%0d_lead_bit", i), 64'(obs_bits[32]), 64'd0);
    checkOutput($sformatf("v%0d_response", i), 64'(obs_bits[31:0]), 64'(v.exp_resp));
    exp_err += v.exp_err_inc;
    checkOutput($sformatf("v%0d_err_count", i), 64'(err_count), 64'(exp_err));
  endtask

  task automatic badFrame(input string name, input int n);
    logic [127:0] fr;
    int strobes;
    int rdys;
    fr = {4{32'h9C3A_51E7}};
    strobes = 0;
    rdys = 0;
    lb_waitrequest = 1'b0;
    sendFrame(fr, n);
    for (int c = 0; c < 40; c++) begin
      @(negedge csi_MCLK_clk);
      if (lb_write || lb_read) strobes++;
      if (ser_rdy) rdys++;
    end
    exp_err++;
    checkOutput({name, "_strobes"}, 64'(strobes), 64'd0);
    checkOutput({name, "_rdy"}, 64'(rdys), 64'd0);
    checkOutput({name, "_err_count"}, 64'(err_count), 64'(exp_err));
  endtask

  vec_t vecs[7];
  vec_t tail;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0012, 32'hA5A5_1234, 32'h0,         0,    0,  0, 8'h12, 1,  32'h0,         0};
    vecs[1] = '{1'b0, 32'h0000_0040, 32'h0,         32'h8000_0001, 5,    0,  0, 8'h40, 6,  32'h8000_0001, 0};
    vecs[2] = '{1'b0, 32'h0000_007F, 32'h0,         32'h1234_5678, 0,    10, 4, 8'h7F, 1,  32'h1234_5678, 1};
    vecs[3] = '{1'b1, 32'hFFFF_FF03, 32'hFFFF_FFFF, 32'h0BAD_0BAD, 3,    0,  0, 8'h03, 4,  32'h0,         0};
    vecs[4] = '{1'b0, 32'h0000_0055, 32'h0,         32'hCAFE_F00D, 15,   0,  0, 8'h55, 16, 32'hCAFE_F00D, 0};
    vecs[5] = '{1'b0, 32'h0000_0066, 32'h0,         32'h1111_1111, 1000, 0,  0, 8'h66, 16, 32'hDEAD_BEEF, 1};
    vecs[6] = '{1'b1, 32'h0000_0099, 32'h0F0F_0F0F, 32'h0,         1000, 0,  0, 8'h99, 16, 32'hDEAD_BEEF, 1};
    tail    = '{1'b0, 32'h0000_0021, 32'h0,         32'h7654_3210, 2,    0,  0, 8'h21, 3,  32'h7654_3210, 0};

    rsi_MRST_reset = 1'b1;
    ser_le         = 1'b0;
    ser_din        = 1'b0;
    lb_readdata    = '0;
    lb_waitrequest = 1'b0;
    repeat (3) @(negedge csi_MCLK_clk);
    checkOutput("reset_ser_dout", 64'(ser_dout), 64'd0);
    checkOutput("reset_ser_rdy", 64'(ser_rdy), 64'd0);
    checkOutput("reset_lb_write", 64'(lb_write), 64'd0);
    checkOutput("reset_lb_read", 64'(lb_read), 64'd0);
    checkOutput("reset_lb_address", 64'(lb_address), 64'd0);
    checkOutput("reset_lb_writedata", 64'(lb_writedata), 64'd0);
    checkOutput("reset_err_count", 64'(err_count), 64'd0);
    rsi_MRST_reset = 1'b0;
    repeat (2) @(negedge csi_MCLK_clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    badFrame("short64", 64);
    badFrame("long66", 66);
    applyStimulus(vecs[0]);
    checkVector(10, vecs[0]);

    // Reset in the middle of a stalled read.
    lb_waitrequest = 1'b1;
    lb_readdata    = 32'h5555_AAAA;
    sendFrame({63'b0, 1'b0, 32'h0000_0033, 32'h0}, 65);
    repeat (3) @(negedge csi_MCLK_clk);
    checkOutput("midexec_read_active", 64'(lb_read), 64'd1);
    #2 rsi_MRST_reset = 1'b1;
    #1;
    checkOutput("midexec_read_dropped", 64'(lb_read), 64'd0);
    checkOutput("midexec_write_low", 64'(lb_write), 64'd0);
    checkOutput("midexec_rdy_low", 64'(ser_rdy), 64'd0);
    checkOutput("midexec_err_cleared", 64'(err_count), 64'd0);
    @(negedge csi_MCLK_clk);
    rsi_MRST_reset = 1'b0;
    lb_waitrequest = 1'b0;
    exp_err = 0;
    repeat (2) @(negedge csi_MCLK_clk);
    applyStimulus(tail);
    checkVector(11, tail);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qsys_serial_endpoint.md
# qsys_serial_endpoint

Far-end receiver for the Qsys serial link. It captures the 65-bit command frames that the serial bridge shifts out, executes each one as a single access on a local Avalon-style register bus, and shifts a 32-bit response word back to the bridge under ready/enable handshaking. It sits directly downstream of the serial bridge, on the peripheral side of the link, and fronts the local register file.

## Interface
- ADDR_W, 8: local bus address width; taken from frame bits [ADDR_W+31:32].
- LB_TIMEOUT, 255: maximum cycles a local access may wait before it is aborted; valid range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF: response word returned on a timed-out access.
- csi_MCLK_clk  in  1  link and local bus clock (same clock as the bridge)
- rsi_MRST_reset  in  1  asynchronous, active-high reset
- ser_le  in  1  frame enable from the bridge (its sle)
- ser_din  in  1  serial command data from the bridge (its sdo)
- ser_dout  out  1  serial response data to the bridge (its sdi)
- ser_rdy  out  1  response-ready strobe to the bridge (its srdy)
- lb_address  out  ADDR_W  local bus address
- lb_writedata  out  32  local bus write data
- lb_write  out  1  local write strobe
- lb_read  out  1  local read strobe
- lb_readdata  in  32  local read data; valid in the cycle lb_waitrequest is low while lb_read is high
- lb_waitrequest  in  1  local bus stall
- err_count  out  8  saturating count of bad frames and timeouts

## Operation
- Frame format (MSB first): bit 64 = W (1 write, 0 read), bits 63:32 = address, bits 31:0 = write data (don't-care for reads).
- States: IDLE, SHIFT_IN, EXEC, RESP, GAP.
- IDLE: when ser_le=1 at a rising edge, sample ser_din into a 65-bit shift register, set the bit count to 1, and enter SHIFT_IN.
- SHIFT_IN: on every edge with ser_le=1, shift ser_din in at bit 0; the bit count saturates at 127. The first edge with ser_le=0 closes the frame:
  - count = 65: latch W, address and data; enter EXEC.
  - otherwise: increment err_count; return to IDLE; do not access the bus and do not send a response.
- EXEC: drive lb_address and lb_writedata, plus lb_write=W or lb_read=!W. Hold them while lb_waitrequest=1.
  - Completion is the first edge with lb_waitrequest=0. For a read, lb_readdata is captured as the response; for a write, the response is 32'h0. Strobes drop the following cycle; enter RESP.
  - A wait counter increments every EXEC cycle. When it reaches LB_TIMEOUT: drop the strobe, load ERR_DATA as the response, increment err_count, and enter RESP.
- RESP: ser_rdy=1 for exactly 33 consecutive cycles. Cycle 0 drives ser_dout=0 (lead bit, consumed by the bridge's ready detect). Cycles 1..32 drive response bits 31..0. Then enter GAP.
- GAP: one cycle with ser_rdy=0 and ser_dout=0; then IDLE.
- ser_le=1 seen in EXEC, RESP or GAP: the bits are ignored; err_count increments once per such frame, counted on ser_le rising.
- Only one frame is in flight at a time; there is no queueing.
- err_count saturates at 255 and is cleared only by reset.

## Timing
- Reset values: ser_dout=0, ser_rdy=0, lb_write=0, lb_read=0, lb_address=0, lb_writedata=0, err_count=0, state IDLE.
- Reset asserted mid-frame or mid-access aborts immediately and asynchronously. Strobes drop with no completion; the response is not sent.
- All outputs are registered, changing on the rising csi_MCLK_clk.
- Latency from the ser_le fall edge to the first lb strobe: 1 cycle (EXEC entry), so the strobe is visible 1 cycle after the fall.
- Completion to ser_rdy rise: 1 cycle. ser_rdy is high for exactly 33 cycles and then low for at least 1 cycle.
- Zero-wait access, end to end: frame close to ser_rdy rise = 3 cycles.
- Timeout with LB_TIMEOUT=N: the strobe is high for exactly N cycles.
- lb_waitrequest=0 in the same cycle the counter reaches LB_TIMEOUT: completion wins; no error is recorded.

## Test plan
- Write frame W=1, addr=0x12, data=0xA5A5_1234, zero-wait bus -> one lb_write cycle with lb_address=0x12 and lb_writedata=0xA5A5_1234; ser_rdy high 33 cycles; all ser_dout bits 0; err_count=0.
- Read frame addr=0x40, lb_readdata=0x8000_0001, lb_waitrequest high 5 cycles -> lb_read high 6 cycles; response serialises as lead 0, then 1, thirty 0s, then 1.
- Read with lb_waitrequest stuck high, LB_TIMEOUT=16 -> lb_read high 16 cycles; response 0xDEAD_BEEF; err_count=1.
- 64-bit frame and 66-bit frame -> no bus access, no ser_rdy, err_count increments after each; a following valid 65-bit frame completes normally.
- New ser_le burst during RESP -> current response completes unchanged, burst ignored, err_count +1. Separately, reset pulsed mid-EXEC -> strobes and ser_rdy are 0 immediately, and the next frame works.
